// File: rtl/aes_dec_round_sequencer.sv
// aes_dec_round_sequencer: iterative AES inverse-cipher control. Takes one
// ciphertext per handshake, walks round keys NR..0 from a 1-cycle sync-read
// key store, feeds the shared inverse-round datapath once per clock and
// returns the plaintext.
// Ports:
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready/in_ciphertext   ciphertext stream in
//   rk_addr/rk_data               round-key read address (registered) / data
//   dp_state/dp_last/dp_result    inverse-round datapath link
//   out_valid/out_ready/out_plaintext plaintext stream out
//   busy                          high whenever not IDLE
//   abort                         only with AES_DEC_ABORT_EN: drop the block
// Optional feature macro: AES_DEC_ABORT_EN
module aes_dec_round_sequencer #(
    parameter int NR     = 10,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef AES_DEC_ABORT_EN
    input  logic              abort,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_ciphertext,
    output logic [ADDR_W-1:0] rk_addr,
    input  logic [127:0]      rk_data,
    output logic [127:0]      dp_state,
    output logic              dp_last,
    input  logic [127:0]      dp_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_plaintext,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ADDK,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] RK_NR  = ADDR_W'(NR);
    localparam logic [ADDR_W-1:0] RK_NR1 = ADDR_W'(NR - 1);
    localparam logic [ADDR_W-1:0] RK_NR2 = ADDR_W'(NR - 2);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    state_t              fsm_q, fsm_d;
    logic [ADDR_W-1:0]   rk_addr_q, rk_addr_d;
    logic [ADDR_W-1:0]   round_cnt_q, round_cnt_d;
    logic [127:0]        ct_q, ct_d;
    logic [127:0]        state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic                abort_w;

`ifdef AES_DEC_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            rk_addr_q   <= '0;
            round_cnt_q <= '0;
            ct_q        <= '0;
            state_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            rk_addr_q   <= rk_addr_d;
            round_cnt_q <= round_cnt_d;
            ct_q        <= ct_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        rk_addr_d   = rk_addr_q;
        round_cnt_d = round_cnt_q;
        ct_d        = ct_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        dp_last     = 1'b0;

        unique case (fsm_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ct_d      = in_ciphertext;
                    rk_addr_d = RK_NR;
                    fsm_d     = S_FETCH;
                end
            end
            // Key NR is in flight from the store; queue key NR-1 behind it.
            S_FETCH: begin
                rk_addr_d = RK_NR1;
                fsm_d     = S_ADDK;
            end
            S_ADDK: begin
                state_d     = ct_q ^ rk_data;
                rk_addr_d   = RK_NR2;
                round_cnt_d = RK_NR1;
                fsm_d       = S_ROUND;
            end
            // Address runs one key ahead of the data; it bottoms out at 0
            // so key 0 is still presented for FINAL.
            S_ROUND: begin
                state_d     = dp_result;
                round_cnt_d = round_cnt_q - ONE;
                if (rk_addr_q != '0) begin
                    rk_addr_d = rk_addr_q - ONE;
                end
                if (round_cnt_q == ONE) begin
                    fsm_d = S_FINAL;
                end
            end
            S_FINAL: begin
                dp_last     = 1'b1;
                state_d     = dp_result;
                out_valid_d = 1'b1;
                fsm_d       = S_DONE;
            end
            // A new block may enter on the same edge the result leaves.
            S_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = S_IDLE;
                    if (in_valid) begin
                        ct_d      = in_ciphertext;
                        rk_addr_d = RK_NR;
                        fsm_d     = S_FETCH;
                    end
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase

        // Abort wins over any handshake in the same cycle; IDLE ignores it.
        if (abort_w && (fsm_q != S_IDLE)) begin
            fsm_d       = S_IDLE;
            out_valid_d = 1'b0;
            rk_addr_d   = '0;
            ct_d        = ct_q;
            in_ready    = 1'b0;
        end
    end

    assign rk_addr       = rk_addr_q;
    assign dp_state      = state_q;
    assign out_plaintext = state_q;
    assign out_valid     = out_valid_q;
    assign busy          = (fsm_q != S_IDLE);

endmodule

// File: tb/tb_aes_dec_round_sequencer.sv
// tb_aes_dec_round_sequencer: self-checking bench. Acts as key store and
// inverse-round datapath, compares against an AES inverse-cipher model.
module tb_aes_dec_round_sequencer;

    localparam int NR = 10;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_ciphertext;
    logic [AW-1:0] rk_addr;
    logic [127:0]  rk_data;
    logic [127:0]  dp_state;
    logic          dp_last;
    logic [127:0]  dp_result;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_plaintext;
    logic          busy;
`ifdef AES_DEC_ABORT_EN
    logic          abort;
`endif

    int passed = 0;
    int total  = 0;

    logic [127:0] keys [0:15];
    logic [127:0] fk   [0:15];
    logic [127:0] rk   [0:15];

    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    aes_dec_round_sequencer #(.NR(NR), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef AES_DEC_ABORT_EN
        .abort        (abort),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ciphertext(in_ciphertext),
        .rk_addr      (rk_addr),
        .rk_data      (rk_data),
        .dp_state     (dp_state),
        .dp_last      (dp_last),
        .dp_result    (dp_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_plaintext(out_plaintext),
        .busy         (busy)
    );

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, x;
        r = 8'h01; x = a;
        for (int i = 0; i < 8; i++) begin
            if (((254 >> i) & 1) != 0) r = gmul(r, x);
            x = gmul(x, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] a);
        return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    // InvMixCols?(InvSubBytes(InvShiftRows(s)) ^ k); byte i = row i%4, col i/4
    function automatic logic [127:0] inv_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic last);
        logic [127:0] t, u;
        logic [7:0]   x0, x1, x2, x3;
        int           src;
        t = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = r + 4 * ((c - r + 4) % 4);
                t[127-8*(r+4*c) -: 8] = isbox(s[127-8*src -: 8]);
            end
        t = t ^ k;
        if (last) return t;
        u = '0;
        for (int c = 0; c < 4; c++) begin
            x0 = t[127-32*c -: 8];
            x1 = t[119-32*c -: 8];
            x2 = t[111-32*c -: 8];
            x3 = t[103-32*c -: 8];
            u[127-32*c -: 8] = gmul(x0,8'h0e)^gmul(x1,8'h0b)^gmul(x2,8'h0d)^gmul(x3,8'h09);
            u[119-32*c -: 8] = gmul(x0,8'h09)^gmul(x1,8'h0e)^gmul(x2,8'h0b)^gmul(x3,8'h0d);
            u[111-32*c -: 8] = gmul(x0,8'h0d)^gmul(x1,8'h09)^gmul(x2,8'h0e)^gmul(x3,8'h0b);
            u[103-32*c -: 8] = gmul(x0,8'h0b)^gmul(x1,8'h0d)^gmul(x2,8'h09)^gmul(x3,8'h0e);
        end
        return u;
    endfunction

    // Whole-block inverse cipher over the current key store.
    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ keys[NR];
        for (int r = NR - 1; r >= 1; r--) s = inv_round(s, keys[r], 1'b0);
        return inv_round(s, keys[0], 1'b1);
    endfunction

    task automatic expand_fips();
        logic [31:0]  w [0:43];
        logic [31:0]  t;
        logic [7:0]   rcon;
        logic [127:0] key;
        key  = 128'h000102030405060708090a0b0c0d0e0f;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++)
            fk[i] = (i <= NR) ? {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]} : '0;
    endtask

    // ---------------- environment ----------------
    always @(posedge clk) rk_data <= keys[rk_addr];
    assign dp_result = inv_round(dp_state, rk_data, dp_last);

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic load_keys(input logic fips);
        for (int i = 0; i < 16; i++) keys[i] = fips ? fk[i] : rk[i];
    endtask

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] ct);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        chk("in_ready_wait", 128'(in_ready), 128'(1));
        in_valid      = 1'b1;
        in_ciphertext = ct;
        tick();
        in_valid      = 1'b0;
        in_ciphertext = rnd128();
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release", 128'({out_valid, busy}), 128'(0));
    endtask

    task automatic run_vector(input logic [127:0] ct, input logic [127:0] exp,
                              input int hold);
        int n;
        accept(ct);
        wait_out(n);
        chk("latency", 128'(n), 128'(NR + 2));
        chk("plaintext", out_plaintext, exp);
        repeat (hold) tick();
        chk("held", {out_valid, out_plaintext}, {1'b1, exp});
        release_out();
    endtask

    typedef struct {
        logic [127:0] ct;
        logic         fips;
        logic [127:0] exp;
        int           hold;
    } vec_t;

    vec_t vt [8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] c1, c2, e1, e2;
        logic [AW-1:0] ea;
        int n;
        bit seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_ciphertext = '0;
`ifdef AES_DEC_ABORT_EN
        abort = 1'b0;
`endif
        expand_fips();
        for (int i = 0; i < 16; i++) rk[i] = rnd128();
        load_keys(1'b0);

        vt[0] = '{ct: FIPS_CT, fips: 1'b1, exp: FIPS_PT, hold: 2};
        for (int i = 1; i < 8; i++) begin
            vt[i].ct   = rnd128();
            vt[i].fips = 1'b0;
            vt[i].exp  = ref_decrypt(vt[i].ct);
            vt[i].hold = int'($urandom_range(0, 4));
        end

        #12;
        chk("reset_outs", {out_valid, busy, dp_last, rk_addr, dp_state}, '0);
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            load_keys(vt[i].fips);
            run_vector(vt[i].ct, vt[i].exp, vt[i].hold);
        end

        // key address trace and final-round flag for one block
        load_keys(1'b1);
        accept(FIPS_CT);
        for (int k = 0; k < 12; k++) begin
            ea = (k <= 10) ? AW'(10 - k) : '0;
            if (k == 2) chk("addkey_state", dp_state, FIPS_CT ^ fk[NR]);
            if (k == 11) chk("final_key", rk_data, fk[0]);
            chk($sformatf("trace_k%0d", k), 128'({rk_addr, dp_last, in_ready, busy}),
                128'({ea, (k == 11), 1'b0, 1'b1}));
            tick();
        end
        chk("trace_out", {out_valid, out_plaintext}, {1'b1, FIPS_PT});
        release_out();

        // long back-pressure, then same-edge accept of the next block
        load_keys(1'b0);
        c1 = rnd128(); c2 = rnd128();
        e1 = ref_decrypt(c1); e2 = ref_decrypt(c2);
        accept(c1);
        wait_out(n);
        chk("bp_latency", 128'(n), 128'(NR + 2));
        in_valid = 1'b1; in_ciphertext = c2;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_hold", {out_valid, in_ready, out_plaintext}, {1'b1, 1'b0, e1});
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_reaccept", 128'({out_valid, busy}), 128'({1'b0, 1'b1}));
        wait_out(n);
        chk("bp_latency2", 128'(n), 128'(NR + 2));
        chk("bp_plaintext2", out_plaintext, e2);
        release_out();

        // in_valid with another block during ROUND is ignored
        c1 = rnd128(); c2 = rnd128(); e1 = ref_decrypt(c1);
        accept(c1);
        repeat (4) tick();
        in_valid = 1'b1; in_ciphertext = c2;
        #1;
        chk("round_in_ready", 128'(in_ready), 128'(0));
        tick();
        in_valid = 1'b0;
        wait_out(n);
        chk("ignore_latency", 128'(n), 128'(NR + 2 - 5));
        chk("ignore_plaintext", out_plaintext, e1);
        release_out();

        // asynchronous reset mid-block
        accept(rnd128());
        repeat (7) tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_outs", {out_valid, busy, dp_last, rk_addr, dp_state}, '0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_idle", 128'({busy, in_ready, out_valid}), 128'({1'b0, 1'b1, 1'b0}));
        c1 = rnd128();
        run_vector(c1, ref_decrypt(c1), 1);

`ifdef AES_DEC_ABORT_EN
        accept(rnd128());
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_outs", 128'({busy, out_valid, rk_addr}), 128'(0));
        seen = 1'b0;
        repeat (15) begin
            tick();
            seen = seen | out_valid;
        end
        chk("abort_no_out", 128'(seen), 128'(0));
        c1 = rnd128();
        abort = 1'b1; in_valid = 1'b1; in_ciphertext = c1;
        #1;
        chk("abort_idle_ready", 128'(in_ready), 128'(1));
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_idle_busy", 128'(busy), 128'(1));
        wait_out(n);
        chk("abort_idle_latency", 128'(n), 128'(NR + 2));
        chk("abort_idle_pt", out_plaintext, ref_decrypt(c1));
        out_ready = 1'b1; in_valid = 1'b1; abort = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0; abort = 1'b0;
        chk("abort_done", 128'({busy, out_valid}), 128'(0));
`else
        seen = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
